// File: rtl/port_req_queue.sv
// Three per-port request FIFOs feeding a round-robin arbiter, with a registered, backpressured output.
// Optional protocol checker (sticky err port) is compiled in with PORT_REQ_QUEUE_CHK_EN.
module port_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        in_valid,
  output logic [2:0]        in_ready,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic [2:0]        req,
  input  logic [2:0]        grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_port
`ifdef PORT_REQ_QUEUE_CHK_EN
  ,
  output logic              err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem     [3][DEPTH];
  logic [AW-1:0]     wr_ptr  [3];
  logic [AW-1:0]     rd_ptr  [3];
  logic [CW-1:0]     count   [3];
  logic [DATA_W-1:0] in_data [3];

  logic [2:0]        push;
  logic [2:0]        eligible;
  logic [2:0]        pop;
  logic              slot_free;
  logic [DATA_W-1:0] head;

  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;

  // Requests are withheld while the output is stalled, so the arbiter token freezes too.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = '0;
    req       = '0;
    for (int i = 0; i < 3; i++) begin
      in_ready[i] = (count[i] != CW'(DEPTH));
      req[i]      = (count[i] != '0) && slot_free;
    end
  end

  assign push     = in_valid & in_ready;
  assign eligible = grant & req;
  assign pop      = {eligible[2] & ~(|eligible[1:0]), eligible[1] & ~eligible[0], eligible[0]};

  always_comb begin
    head = '0;
    for (int i = 0; i < 3; i++) begin
      if (pop[i]) head = mem[i][rd_ptr[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Data and port hold their last value after the consumer drains the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else if (|pop) begin
      out_valid <= 1'b1;
      out_data  <= head;
      out_port  <= pop;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PORT_REQ_QUEUE_CHK_EN
  logic err_cond;

  assign err_cond = ((grant & (grant - 3'd1)) != 3'b000) ||
                    ((grant & ~req) != 3'b000) ||
                    ((in_valid & ~in_ready) != 3'b000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         err <= 1'b0;
    else if (err_cond) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_port_req_queue.sv
// Scoreboard bench for port_req_queue: a round-robin arbiter model drives grant, a monitor checks every output handshake.
module tb_port_req_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        in_valid;
  logic [2:0]        in_ready;
  logic [DATA_W-1:0] in_data0, in_data1, in_data2;
  logic [2:0]        req;
  logic [2:0]        grant;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_port;
`ifdef PORT_REQ_QUEUE_CHK_EN
  logic              err;
`endif

  logic [2:0]  arb_grant;
  logic [2:0]  force_grant;
  logic        use_arb;
  logic [1:0]  token;
  logic [10:0] sb[$];
  logic [10:0] exp_entry;
  int          errors = 0;
  int          checks = 0;

  port_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .req(req), .grant(grant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_port(out_port)
`ifdef PORT_REQ_QUEUE_CHK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rrPick(input logic [2:0] r, input logic [1:0] t);
    logic [2:0] g;
    int p;
    g = '0;
    for (int k = 0; k < 3; k++) begin
      p = (int'(t) + k) % 3;
      if (g == 3'b000 && r[p]) g[p] = 1'b1;
    end
    return g;
  endfunction

  always_comb arb_grant = rrPick(req, token);
  assign grant = use_arb ? arb_grant : force_grant;

  // Token moves just past the last granted port.
  always @(posedge clk or posedge reset) begin
    if (reset) token <= 2'd0;
    else if (use_arb) begin
      if (grant[0])      token <= 2'd1;
      else if (grant[1]) token <= 2'd2;
      else if (grant[2]) token <= 2'd0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got port 0x%0h data 0x%0h expected none", out_port, out_data);
      end else begin
        exp_entry = sb.pop_front();
        checkOutput("out_port", int'(out_port), int'(exp_entry[10:8]));
        checkOutput("out_data", int'(out_data), int'(exp_entry[7:0]));
      end
    end
  end

  task automatic expectOut(input logic [2:0] port, input logic [7:0] data);
    sb.push_back({port, data});
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    in_valid = valid;
    in_data0 = d0;
    in_data1 = d1;
    in_data2 = d2;
    step(1);
    in_valid = '0;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    in_valid    = '0;
    use_arb     = 1'b1;
    force_grant = '0;
    out_ready   = 1'b1;
    sb.delete();
    step(2);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    checkOutput("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_data0 = '0; in_data1 = '0; in_data2 = '0;
    doReset();

    // Reset state
    checkOutput("rst_req", int'(req), 0);
    checkOutput("rst_in_ready", int'(in_ready), 7);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_port", int'(out_port), 0);

    // Two entries on port 0, back to back
    expectOut(3'b001, 8'hA1);
    expectOut(3'b001, 8'hA2);
    applyStimulus(3'b001, 8'hA1, 8'h00, 8'h00);
    applyStimulus(3'b001, 8'hA2, 8'h00, 8'h00);
    step(1);
    checkOutput("req0_drop", int'(req), 0);
    drain(10);

    // One entry per port in the same cycle
    doReset();
    expectOut(3'b001, 8'h11);
    expectOut(3'b010, 8'h22);
    expectOut(3'b100, 8'h33);
    applyStimulus(3'b111, 8'h11, 8'h22, 8'h33);
    drain(10);

    // Fill port 1, then push across the pointer wrap
    doReset();
    use_arb = 1'b0;
    for (int k = 0; k < 5; k++) expectOut(3'b010, 8'(8'h40 + k));
    for (int k = 0; k < 4; k++) applyStimulus(3'b010, 8'h00, 8'(8'h40 + k), 8'h00);
    checkOutput("full_in_ready", int'(in_ready), 5);
    use_arb = 1'b1;
    step(1);
    checkOutput("after_pop_in_ready", int'(in_ready), 7);
    applyStimulus(3'b010, 8'h00, 8'h44, 8'h00);
    drain(12);

    // Output stall holds req low and data stable
    doReset();
    use_arb   = 1'b0;
    out_ready = 1'b0;
    expectOut(3'b001, 8'h51);
    expectOut(3'b001, 8'h52);
    expectOut(3'b001, 8'h53);
    applyStimulus(3'b001, 8'h51, 8'h00, 8'h00);
    applyStimulus(3'b001, 8'h52, 8'h00, 8'h00);
    applyStimulus(3'b001, 8'h53, 8'h00, 8'h00);
    use_arb = 1'b1;
    step(1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_req", int'(req), 0);
      checkOutput("stall_data", int'(out_data), 8'h51);
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    checkOutput("resume_data", int'(out_data), 8'h52);
    drain(10);

    // Illegal multi-hot grant: only the lowest requesting port pops
    doReset();
    use_arb = 1'b0;
    expectOut(3'b001, 8'h61);
    expectOut(3'b010, 8'h62);
    applyStimulus(3'b011, 8'h61, 8'h62, 8'h00);
    force_grant = 3'b011;
    step(1);
    force_grant = 3'b000;
    checkOutput("multihot_port", int'(out_port), 1);
    checkOutput("multihot_req_left", int'(req), 2);
`ifdef PORT_REQ_QUEUE_CHK_EN
    checkOutput("err_multihot", int'(err), 1);
    step(3);
    checkOutput("err_sticky", int'(err), 1);
`endif
    use_arb = 1'b1;
    drain(10);
`ifdef PORT_REQ_QUEUE_CHK_EN
    doReset();
    checkOutput("err_cleared", int'(err), 0);
`endif

    // Grant to an empty port is ignored
    doReset();
    use_arb     = 1'b0;
    force_grant = 3'b100;
    step(1);
    force_grant = 3'b000;
    checkOutput("empty_grant_valid", int'(out_valid), 0);
    checkOutput("empty_grant_in_ready", int'(in_ready), 7);
`ifdef PORT_REQ_QUEUE_CHK_EN
    checkOutput("err_empty_grant", int'(err), 1);
`endif

    // Asynchronous reset mid-operation discards everything
    doReset();
    use_arb   = 1'b0;
    out_ready = 1'b0;
    applyStimulus(3'b001, 8'h71, 8'h00, 8'h00);
    applyStimulus(3'b001, 8'h72, 8'h00, 8'h00);
    use_arb = 1'b1;
    step(1);
    checkOutput("pre_reset_valid", int'(out_valid), 1);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_rst_valid", int'(out_valid), 0);
    checkOutput("async_rst_req", int'(req), 0);
    checkOutput("async_rst_in_ready", int'(in_ready), 7);
    step(2);
    reset     = 1'b0;
    out_ready = 1'b1;
    step(3);
    checkOutput("post_rst_idle", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/port_req_queue.md
# port_req_queue

Per-port request queue stage directly upstream of the 3-port round-robin grant arbiter. It buffers transactions from three independent producers in small FIFOs and drives the arbiter's `req[2:0]` from FIFO non-empty status. It pops the granted port's head entry in the same cycle the arbiter's combinational `grant[2:0]` is seen. The popped entry is presented on a registered, backpressured output toward the shared consumer.

## Interface
- `DATA_W`, default 8: payload width per entry.
- `DEPTH`, default 4: entries per port FIFO; a power of 2, at least 2.
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `in_valid` input, 3: per-port push request.
- `in_ready` output, 3: per-port accept; `in_ready[i] = (count[i] != DEPTH)`.
- `in_data0`, `in_data1`, `in_data2` input, DATA_W each: per-port payload.
- `req` output, 3: to arbiter `req`.
- `grant` input, 3: from arbiter `grant`; one-hot or zero, combinational from `req`.
- `out_valid` output, 1: output register holds an entry.
- `out_ready` input, 1: consumer accepts the output this cycle.
- `out_data` output, DATA_W: payload of the popped entry.
- `out_port` output, 3: one-hot source port of `out_data`.
- `err` output, 1: sticky protocol error. Present only with `PORT_REQ_QUEUE_CHK_EN`.

## Operation
- Each port has a FIFO of DEPTH×DATA_W, with write pointer, read pointer and count. Count is `$clog2(DEPTH)+1` bits wide. Pointers wrap modulo DEPTH.
- Push: `in_valid[i] && in_ready[i]` writes `in_data<i>` at the write pointer, then write pointer +1 and count +1.
- A full FIFO deasserts `in_ready[i]`. There is no same-cycle pop/push bypass when full.
- The output slot is free when `!out_valid || out_ready`.
- `req[i] = (count[i] != 0) && slot_free`. The arbiter therefore never grants while the output is stalled.
- Pop: `grant[i] && req[i]`.
  - Reads the head at the read pointer.
  - Loads `out_data` with the head and `out_port` with `grant`, and sets `out_valid`.
  - Read pointer +1, count −1.
- Simultaneous push and pop on the same port: count is unchanged and both pointers advance.
- Output register update, each cycle:
  - Pop → load the new entry; `out_valid` = 1.
  - Otherwise, if `out_ready` → `out_valid` = 0, and `out_data`/`out_port` hold their values.
  - Otherwise → hold.
- Multi-hot `grant` (illegal): only the lowest-indexed bit that is also set in `req` pops.
- A grant bit set while the corresponding `req` is 0 is ignored: no pop, no output change.

## Timing
- Reset values: all FIFOs empty and pointers 0, so `req` = 000 and `in_ready` = 111. `out_valid` = 0, `out_data` = 0, `out_port` = 000, `err` = 0.
- Reset asserted mid-operation discards all queued and output entries immediately (asynchronous).
- Push to first visible `req`: 1 cycle. An entry pushed at edge N gives `req[i]` = 1 after edge N; there is no fall-through.
- Grant to output: 1 cycle. A pop sampled at edge N gives `out_valid` = 1 with the payload after edge N.
- Back-to-back throughput: 1 entry per cycle while `out_ready` is held at 1.
- Output-stall interaction: with `out_valid` = 1 and `out_ready` = 0, `req` = 000 and the arbiter's token does not advance.
- Data order: FIFO order is preserved within a port. Interleaving across ports is decided by the arbiter.

## Configuration
- Macro `PORT_REQ_QUEUE_CHK_EN`.
- Defined: the `err` port exists. It is set on the next edge and held until reset on any of:
  - `grant` not zero and not one-hot;
  - `grant[i]` while `req[i]` = 0;
  - `in_valid[i]` while `in_ready[i]` = 0.
- Not defined: the `err` port and all check logic are removed. Functional behaviour is identical.

## Test plan
- Reset then idle → `req` = 000, `in_ready` = 111, `out_valid` = 0, `out_data` = 0.
- Push 0xA1, 0xA2 on port 0; arbiter token at PORT0; `out_ready` = 1 → `out_data` 0xA1 then 0xA2 on consecutive cycles; `out_port` = 001; `req[0]` drops after the second pop.
- Push 0x11 on port 0, 0x22 on port 1 and 0x33 on port 2 in the same cycle; arbiter attached → outputs 0x11/001, 0x22/010, 0x33/100 over three cycles.
- Fill port 1 with DEPTH=4 entries (0x40..0x43) → `in_ready[1]` = 0. A fifth push is held until after the first pop; order 0x40..0x44 is preserved across pointer wrap.
- `out_ready` = 0 with `out_valid` = 1 and entries pending → `req` = 000 and `out_data` stable for 5 cycles. Raising `out_ready` resumes with the next entry 1 cycle later.
- With `PORT_REQ_QUEUE_CHK_EN`: force `grant` = 011, or `grant` = 100 while port 2 is empty → `err` = 1 after the edge, held until `reset`. Without the macro the same stimulus causes no pop on the empty port.
